pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core.
- Tracks destinations of in-flight instructions in EX and ME with a small scoreboard.
- Produces the registered forwarding selects that drive the execute-stage rs1/rs2 muxes.
- Detects load-use hazards and EX-resolved branch/jump redirects; issues stall, bubble and flush controls to the IF/ID and ID/EX pipeline registers.

---
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard/forwarding sequencer for the 5-stage core. Optional
//               multi-cycle mul/div occupancy enabled by PIPE_HAZARD_CTRL_MULDIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MULDIV_LAT = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_ren,
    input  logic                  id_rs2_ren,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_wen,
    input  logic                  id_is_load,
    input  logic                  id_is_jump,
    input  logic                  id_is_muldiv,
    input  logic                  ex_b_flag,
    input  logic                  me_stall,
    output logic [1:0]            ex_rs1_src,
    output logic [1:0]            ex_rs2_src,
    output logic                  stall_front,
    output logic                  bubble_ex,
    output logic                  flush_id,
    output logic                  redirect,
    output logic                  ex_valid,
    output logic                  muldiv_busy
);

    localparam logic [1:0] c_SRC_RF = 2'b00;
    localparam logic [1:0] c_SRC_ME = 2'b01;
    localparam logic [1:0] c_SRC_WB = 2'b10;

    logic                  r_ex_valid;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_ex_wen;
    logic                  r_ex_load;
    logic                  r_ex_jump;
    logic                  r_me_valid;
    logic [REG_ADDR_W-1:0] r_me_rd;
    logic                  r_me_wen;
    logic [1:0]            r_rs1_src;
    logic [1:0]            r_rs2_src;

    logic       w_rs1_ex, w_rs2_ex, w_rs1_me, w_rs2_me;
    logic       w_busy, w_redir, w_load_use, w_advance;
    logic [1:0] w_rs1_enc, w_rs2_enc;

    function automatic logic f_match(
        input logic                  ren,
        input logic [REG_ADDR_W-1:0] idx,
        input logic                  stg_valid,
        input logic                  stg_wen,
        input logic [REG_ADDR_W-1:0] stg_rd
    );
        return ren && (idx != '0) && stg_valid && stg_wen && (stg_rd == idx);
    endfunction

    assign w_rs1_ex = f_match(id_rs1_ren, id_rs1, r_ex_valid, r_ex_wen, r_ex_rd);
    assign w_rs2_ex = f_match(id_rs2_ren, id_rs2, r_ex_valid, r_ex_wen, r_ex_rd);
    assign w_rs1_me = f_match(id_rs1_ren, id_rs1, r_me_valid, r_me_wen, r_me_rd);
    assign w_rs2_me = f_match(id_rs2_ren, id_rs2, r_me_valid, r_me_wen, r_me_rd);

    // EX holds the younger producer, so it wins over ME
    assign w_rs1_enc = w_rs1_ex ? c_SRC_ME : (w_rs1_me ? c_SRC_WB : c_SRC_RF);
    assign w_rs2_enc = w_rs2_ex ? c_SRC_ME : (w_rs2_me ? c_SRC_WB : c_SRC_RF);

    assign w_redir    = r_ex_valid && (r_ex_jump || ex_b_flag);
    assign w_load_use = r_ex_valid && r_ex_load && id_valid && (w_rs1_ex || w_rs2_ex);
    assign w_advance  = !me_stall && !w_busy && !w_redir && !w_load_use;

`ifdef PIPE_HAZARD_CTRL_MULDIV_EN
    localparam int                c_CNT_W  = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAT_M1 = c_CNT_W'(MULDIV_LAT - 1);

    logic               r_ex_muldiv;
    logic [c_CNT_W-1:0] r_md_cnt;

    assign w_busy = r_ex_valid && r_ex_muldiv && (r_md_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_muldiv <= 1'b0;
            r_md_cnt    <= '0;
        end else if (!me_stall) begin
            if (w_busy) begin
                r_md_cnt <= r_md_cnt - 1'b1;
            end else if (w_advance) begin
                r_ex_muldiv <= id_valid && id_is_muldiv;
                r_md_cnt    <= (id_valid && id_is_muldiv) ? c_LAT_M1 : '0;
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = id_is_muldiv ^ (MULDIV_LAT == 0);
    assign w_busy   = 1'b0;
`endif

    always_comb begin
        stall_front = 1'b0;
        bubble_ex   = 1'b0;
        flush_id    = 1'b0;
        redirect    = 1'b0;
        if (me_stall || w_busy) begin
            stall_front = 1'b1;
        end else if (w_redir) begin
            redirect  = 1'b1;
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (w_load_use) begin
            stall_front = 1'b1;
            bubble_ex   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_rd    <= '0;
            r_ex_wen   <= 1'b0;
            r_ex_load  <= 1'b0;
            r_ex_jump  <= 1'b0;
            r_me_valid <= 1'b0;
            r_me_rd    <= '0;
            r_me_wen   <= 1'b0;
            r_rs1_src  <= c_SRC_RF;
            r_rs2_src  <= c_SRC_RF;
        end else if (!me_stall) begin
            if (w_busy) begin
                r_me_valid <= 1'b0;
            end else begin
                r_me_valid <= r_ex_valid;
                r_me_rd    <= r_ex_rd;
                r_me_wen   <= r_ex_wen;
                if (w_redir || w_load_use) begin
                    r_ex_valid <= 1'b0;
                end else begin
                    r_ex_valid <= id_valid;
                    r_ex_rd    <= id_rd;
                    r_ex_wen   <= id_rd_wen;
                    r_ex_load  <= id_is_load;
                    r_ex_jump  <= id_is_jump;
                    r_rs1_src  <= id_valid ? w_rs1_enc : c_SRC_RF;
                    r_rs2_src  <= id_valid ? w_rs2_enc : c_SRC_RF;
                end
            end
        end
    end

    assign ex_rs1_src  = r_rs1_src;
    assign ex_rs2_src  = r_rs2_src;
    assign ex_valid    = r_ex_valid;
    assign muldiv_busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed scoreboard bench for pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_ren, id_rs2_ren, id_rd_wen;
    logic       id_is_load, id_is_jump, id_is_muldiv;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_b_flag, me_stall;
    logic [1:0] ex_rs1_src, ex_rs2_src;
    logic       stall_front, bubble_ex, flush_id, redirect, ex_valid, muldiv_busy;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MULDIV_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen),
        .id_is_load(id_is_load), .id_is_jump(id_is_jump), .id_is_muldiv(id_is_muldiv),
        .ex_b_flag(ex_b_flag), .me_stall(me_stall),
        .ex_rs1_src(ex_rs1_src), .ex_rs2_src(ex_rs2_src),
        .stall_front(stall_front), .bubble_ex(bubble_ex), .flush_id(flush_id),
        .redirect(redirect), .ex_valid(ex_valid), .muldiv_busy(muldiv_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [9:0] vec;
        bit         chk_src;
    } exp_t;

    exp_t q[$];
    int   cycle = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: vector order {src1,src2,stall,bubble,flush,redirect,ex_valid,busy}
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cycle) begin
            exp_t       e;
            logic [9:0] act;
            logic [9:0] mask;
            e    = q.pop_front();
            act  = {ex_rs1_src, ex_rs2_src, stall_front, bubble_ex, flush_id,
                    redirect, ex_valid, muldiv_busy};
            mask = e.chk_src ? 10'h3FF : 10'h0FF;
            n_checks++;
            if (e.cyc != cycle || (act & mask) !== (e.vec & mask)) begin
                n_fail++;
                $display("FAIL %s cycle %0d: actual %b required %b (mask %b)",
                         e.name, cycle, act, e.vec, mask);
            end
        end
    end

    task automatic chk(input string nm, input logic [1:0] s1, input logic [1:0] s2,
                       input logic st, input logic bu, input logic fl, input logic rd,
                       input logic ev, input logic mb, input bit cs);
        exp_t e;
        e.cyc     = cycle;
        e.name    = nm;
        e.vec     = {s1, s2, st, bu, fl, rd, ev, mb};
        e.chk_src = cs;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic [4:0] rs1, input logic r1en, input logic [4:0] rs2,
                          input logic r2en, input logic [4:0] rd, input logic wen,
                          input logic ld, input logic jp, input logic md);
        id_valid = 1'b1; id_rs1 = rs1; id_rs1_ren = r1en; id_rs2 = rs2; id_rs2_ren = r2en;
        id_rd = rd; id_rd_wen = wen; id_is_load = ld; id_is_jump = jp; id_is_muldiv = md;
    endtask

    task automatic id_none();
        id_valid = 1'b0; id_rs1 = '0; id_rs1_ren = 1'b0; id_rs2 = '0; id_rs2_ren = 1'b0;
        id_rd = '0; id_rd_wen = 1'b0; id_is_load = 1'b0; id_is_jump = 1'b0; id_is_muldiv = 1'b0;
    endtask

    task automatic idle(input int n);
        id_none();
        ex_b_flag = 1'b0; me_stall = 1'b0; rst = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ex_b_flag = 1'b0; me_stall = 1'b0;
        id_none();
        tick();
        chk("reset", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1); tick();
        rst = 1'b0;

        // back-to-back ALU dependency forwards from ME
        idle(2);
        id_set(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0); tick();
        id_set(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0);
        chk("alu_b2b_nostall", 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1); tick();
        id_none();
        chk("alu_b2b_fwd", 2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 1); tick();

        // producer two ahead forwards from WB; x0 never forwarded
        idle(2);
        id_set(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0); tick();
        id_set(5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0); tick();
        id_set(5'd0, 1, 5'd5, 1, 5'd7, 1, 0, 0, 0); tick();
        id_none();
        chk("wb_fwd_x0", 2'b00, 2'b10, 0, 0, 0, 0, 1, 0, 1); tick();

        // load-use: one stall + bubble, then WB forwarding on both sources
        idle(2);
        id_set(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0); tick();
        id_set(5'd5, 1, 5'd5, 1, 5'd7, 1, 0, 0, 0);
        chk("ldu_stall", 2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1); tick();
        chk("ldu_release", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1); tick();
        id_none();
        chk("ldu_fwd", 2'b10, 2'b10, 0, 0, 0, 0, 1, 0, 1); tick();

        // taken branch redirect; b_flag with empty EX does nothing
        idle(2);
        id_set(5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 0, 0); tick();
        id_set(5'd3, 1, 5'd4, 1, 5'd8, 1, 0, 0, 0); ex_b_flag = 1'b1;
        chk("br_redirect", 2'b00, 2'b00, 0, 1, 1, 1, 1, 0, 1); tick();
        id_set(5'd3, 1, 5'd4, 1, 5'd9, 1, 0, 0, 0);
        chk("br_after", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0); tick();

        // jump redirects without b_flag
        idle(2);
        id_set(5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 1, 0); tick();
        id_set(5'd3, 1, 5'd4, 1, 5'd8, 1, 0, 0, 0);
        chk("jmp_redirect", 2'b00, 2'b00, 0, 1, 1, 1, 1, 0, 1); tick();
        id_set(5'd3, 1, 5'd4, 1, 5'd9, 1, 0, 0, 0);
        chk("jmp_after", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0); tick();

        // redirect deferred while ME stalls
        idle(2);
        id_set(5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 0, 0); tick();
        id_set(5'd3, 1, 5'd4, 1, 5'd8, 1, 0, 0, 0); ex_b_flag = 1'b1; me_stall = 1'b1;
        chk("redir_deferred", 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0); tick();
        me_stall = 1'b0;
        chk("redir_released", 2'b00, 2'b00, 0, 1, 1, 1, 1, 0, 0); tick();

        // ME stall over a load-use: src held, exactly one bubble afterwards
        idle(2);
        id_set(5'd2, 1, 5'd3, 1, 5'd1, 1, 0, 0, 0); tick();
        id_set(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0); tick();
        id_set(5'd5, 1, 5'd5, 1, 5'd7, 1, 0, 0, 0); me_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("mestall_hold", 2'b01, 2'b00, 1, 0, 0, 0, 1, 0, 1); tick();
        end
        me_stall = 1'b0;
        chk("mestall_ldu_bubble", 2'b01, 2'b00, 1, 1, 0, 0, 1, 0, 1); tick();
        chk("mestall_no_2nd_bubble", 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 1); tick();
        id_none();
        chk("mestall_fwd", 2'b10, 2'b10, 0, 0, 0, 0, 1, 0, 1); tick();

        // reset in the middle of a stall
        idle(2);
        id_set(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0); tick();
        id_set(5'd5, 1, 5'd5, 1, 5'd7, 1, 0, 0, 0); me_stall = 1'b1; rst = 1'b1;
        chk("rst_in_stall", 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0); tick();
        rst = 1'b0; me_stall = 1'b0; id_none();
        chk("rst_cleared", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1); tick();

`ifdef PIPE_HAZARD_CTRL_MULDIV_EN
        // mul/div occupies EX for MULDIV_LAT-1 extra cycles
        idle(2);
        id_set(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 1); tick();
        id_set(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("md_busy", 2'b00, 2'b00, 1, 0, 0, 0, 1, 1, 0); tick();
        end
        chk("md_done", 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0); tick();
        id_none();
        chk("md_fwd", 2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 1); tick();
        idle(2);
        id_set(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 1); tick();
        id_set(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0); rst = 1'b1;
        chk("md_rst_busy", 2'b00, 2'b00, 1, 0, 0, 0, 1, 1, 0); tick();
        rst = 1'b0; id_none();
        chk("md_rst_cleared", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1); tick();
`else
        // without the feature a mul/div behaves like any ALU op
        idle(2);
        id_set(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 1); tick();
        id_set(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0);
        chk("md_off_nobusy", 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0); tick();
        id_none();
        chk("md_off_fwd", 2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 1); tick();
`endif

        idle(2);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
